iq_readout_core: RTL
====================

# iq_readout_core

Parametrised single-shot qubit readout core that replaces the fixed 5-lane demodulation chain. On each trigger it waits a programmable delay, then counter-rotates `LANES` I/Q samples per clock by a mod-`PHASE_MOD` demodulation phase. It integrates the rotated samples over a programmable window and queues each (I, Q) result in a small FIFO drained by a valid/ready handshake. It sits between the ADC lane buses and the state-analysis/binning logic.

## Interface
- `LANES`, 5, samples per clock per channel.
- `DATA_W`, 16, signed sample width.
- `COEF_W`, 16, signed cos/sin coefficient width. Coefficients are Q2.14; 1.0 = 16383.
- `ACC_W`, 40, signed accumulator/result width.
- `LEN_W`, 16, integration-length counter width.
- `DELAY_W`, 16, delay counter width.
- `PHASE_MOD`, 50, phase steps per full turn.
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2).
- `clk100`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high; clears all state.
- `cfg_demod_freq`  in  6  phase increment per sample; reduced mod `PHASE_MOD`.
- `cfg_delay`  in  `DELAY_W`  cycles between trigger and the first integrated sample cycle.
- `cfg_length`  in  `LEN_W`  integration window in clock cycles (×`LANES` samples).
- `trigger`  in  1  start-of-shot strobe.
- `data_i_in`  in  `LANES*DATA_W`  I samples; lane 0 in the LSBs is the earliest sample.
- `data_q_in`  in  `LANES*DATA_W`  Q samples, same packing.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  consumer accepts the head.
- `res_i`  out  `ACC_W`  integrated I.
- `res_q`  out  `ACC_W`  integrated Q.
- `busy`  out  1  high outside IDLE.
- `trig_missed`  out  1  one-cycle pulse when a trigger is ignored.
- `overflow_err`  out  1  sticky; a result was dropped because the FIFO was full.

## Operation
- Reset values: all outputs 0, FIFO empty, state IDLE.
- FSM states:
  - IDLE: on `trigger` it latches the cfg_* inputs, clears the accumulators and the phase base, then goes to DELAY. With latched delay = 0 it goes straight to INTEGRATE.
  - DELAY: counts latched delay cycles, then goes to INTEGRATE.
  - INTEGRATE: feeds `cfg_length` input cycles into the pipeline. If latched length = 0 it skips to DRAIN with no samples.
  - DRAIN: waits 3 cycles for the pipeline to empty, then goes to PUSH.
  - PUSH: writes {acc_i, acc_q} to the FIFO, then returns to IDLE.
- A `trigger` seen outside IDLE is ignored and pulses `trig_missed`. The cfg_* inputs are only sampled in IDLE.
- Phase of sample n within a shot (n = LANES·k + lane, k = integrate cycle index) is (f·n) mod `PHASE_MOD`.
  - The base phase advances each cycle by (f·LANES) mod `PHASE_MOD`.
  - Lane phase = (base + (f·lane) mod `PHASE_MOD`) mod `PHASE_MOD`.
  - All terms use conditional subtraction; there are no dividers.
- Coefficient LUT: cos[k] = round(16383·cos(2πk/`PHASE_MOD`)), sin likewise, computed at elaboration.
- Counter-rotation per lane:
  - i_rot = i·cos + q·sin
  - q_rot = q·cos − i·sin
  - Products are kept at full width, `DATA_W+COEF_W+1` bits.
- Pipeline:
  - S1 registers data and lane phases.
  - S2 registers the products.
  - S3 registers the sign-extended sum across lanes.
  - The accumulator adds S3 while the S3 valid bit is high.
- Accumulators wrap modulo 2^`ACC_W`; there is no saturation.
- FIFO:
  - Push in PUSH, pop on `res_valid && res_ready`.
  - When full, a pop and a push in the same cycle both succeed.
  - When full with no pop, the push is dropped and `overflow_err` is set.
  - `res_i`/`res_q` are registered outputs and hold their value while `res_valid && !res_ready`.
- `reset` in any state aborts the shot, empties the FIFO, and clears `overflow_err`.

## Timing
- `trigger` sampled high in IDLE at cycle t:
  - `busy` goes high at t+1.
  - The first integrated input cycle is t+1+D.
  - The last integrated input cycle is t+D+L.
- The FIFO write occurs at cycle t+D+L+4. With an empty FIFO, `res_valid` rises at t+D+L+5.
- `busy` falls the cycle after PUSH, so a new trigger is accepted at t+D+L+5.
- L = 0: the write occurs at t+D+4 with result (0, 0).
- `trig_missed` is asserted on the cycle after the ignored trigger.
- Throughput: one shot per D+L+5 cycles.

## Test plan
- f=0, D=0, L=4, LANES=5, all I=100, Q=0 -> one result, res_i=100·16383·20=32,766,000, res_q=0; `res_valid` at t+9.
- f=25, L=4, constant I=100, Q=0 -> phases alternate 0/25, res_i=0, res_q=0 (sin[25]=0).
- D=3, L=1, data non-zero only at cycle t+4 (I=1 on lane 0, f=0) -> res_i=16383. Moving the marker to t+3 or t+5 -> res_i=0.
- `res_ready`=0, five back-to-back shots with FIFO_DEPTH=4 -> four results retained in order, `overflow_err`=1. Raising `res_ready` drains exactly four with `res_valid` held stable per entry.
- Trigger re-asserted during DELAY and INTEGRATE -> `trig_missed` pulses each time, exactly one result, value unchanged.
- `reset` mid-INTEGRATE then a fresh shot -> `res_valid`=0 after reset, and the next result equals an isolated run with no carry-over.

Source files
------------

// File: rtl/iq_readout_core.sv
// Single-shot I/Q readout: delay, counter-rotate LANES samples/clk, integrate, queue (I,Q) results.
// Result written D+L+4 cycles after trigger; FIFO drains on valid/ready, full+no-pop drops and sets overflow_err.
module iq_readout_core #(
  parameter int LANES      = 5,
  parameter int DATA_W     = 16,
  parameter int COEF_W     = 16,
  parameter int ACC_W      = 40,
  parameter int LEN_W      = 16,
  parameter int DELAY_W    = 16,
  parameter int PHASE_MOD  = 50,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk100,
  input  logic                      reset,
  input  logic [5:0]                cfg_demod_freq,
  input  logic [DELAY_W-1:0]        cfg_delay,
  input  logic [LEN_W-1:0]          cfg_length,
  input  logic                      trigger,
  input  logic [LANES*DATA_W-1:0]   data_i_in,
  input  logic [LANES*DATA_W-1:0]   data_q_in,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_i,
  output logic [ACC_W-1:0]          res_q,
  output logic                      busy,
  output logic                      trig_missed,
  output logic                      overflow_err
);
  localparam int PH_W  = $clog2(PHASE_MOD);
  localparam int MW    = DATA_W + COEF_W;
  localparam int PW    = DATA_W + COEF_W + 1;
  localparam int CNT_W = (LEN_W > DELAY_W) ? LEN_W : DELAY_W;
  localparam real TWO_PI = 6.283185307179586;
  localparam real SCALE  = real'((1 << (COEF_W - 2)) - 1);

  typedef enum logic [2:0] {IDLE, DELAY, INTEGRATE, DRAIN, PUSH} state_t;
  state_t state, state_nxt;

  function automatic logic [PH_W-1:0] add_mod(input logic [PH_W-1:0] a, input logic [PH_W-1:0] b);
    logic [PH_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PH_W+1)'(PHASE_MOD)) s = s - (PH_W+1)'(PHASE_MOD);
    return s[PH_W-1:0];
  endfunction

  function automatic int round_coef(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
  endfunction

  logic signed [COEF_W-1:0] cos_lut [PHASE_MOD];
  logic signed [COEF_W-1:0] sin_lut [PHASE_MOD];
  for (genvar k = 0; k < PHASE_MOD; k++) begin : g_lut
    localparam int COS_K = round_coef(SCALE * $cos(TWO_PI * k / PHASE_MOD));
    localparam int SIN_K = round_coef(SCALE * $sin(TWO_PI * k / PHASE_MOD));
    assign cos_lut[k] = COEF_W'(COS_K);
    assign sin_lut[k] = COEF_W'(SIN_K);
  end

  logic [PH_W-1:0]    freq_red, f_q, base, step;
  logic [PH_W-1:0]    lane_off [LANES];
  logic [DELAY_W-1:0] delay_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    freq_red = (cfg_demod_freq >= 6'(PHASE_MOD)) ? PH_W'(cfg_demod_freq - 6'(PHASE_MOD))
                                                  : PH_W'(cfg_demod_freq);
    lane_off[0] = '0;
    for (int l = 1; l < LANES; l++) lane_off[l] = add_mod(lane_off[l-1], f_q);
    step = add_mod(lane_off[LANES-1], f_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (trigger) begin
          if (cfg_delay != '0)       state_nxt = DELAY;
          else if (cfg_length != '0) state_nxt = INTEGRATE;
          else                       state_nxt = DRAIN;
        end
      DELAY:
        if (cnt == CNT_W'(delay_q - 1'b1)) state_nxt = (len_q != '0) ? INTEGRATE : DRAIN;
      INTEGRATE:
        if (cnt == CNT_W'(len_q - 1'b1)) state_nxt = DRAIN;
      DRAIN:
        if (cnt == CNT_W'(2)) state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign busy = (state != IDLE);

  // Shot control: cfg latch, per-state cycle counter, phase base.
  always_ff @(posedge clk100) begin
    if (reset) begin
      f_q         <= '0;
      delay_q     <= '0;
      len_q       <= '0;
      cnt         <= '0;
      base        <= '0;
      trig_missed <= 1'b0;
    end else begin
      trig_missed <= trigger && (state != IDLE);
      cnt         <= (state == IDLE || state_nxt != state) ? '0 : cnt + 1'b1;
      if (state == IDLE && trigger) begin
        f_q     <= freq_red;
        delay_q <= cfg_delay;
        len_q   <= cfg_length;
        base    <= '0;
      end else if (state == INTEGRATE) begin
        base <= add_mod(base, step);
      end
    end
  end

  logic                     v1, v2, v3;
  logic signed [DATA_W-1:0] s1_i [LANES];
  logic signed [DATA_W-1:0] s1_q [LANES];
  logic [PH_W-1:0]          s1_ph [LANES];
  logic signed [PW-1:0]     p_i [LANES];
  logic signed [PW-1:0]     p_q [LANES];
  logic signed [PW-1:0]     s2_i [LANES];
  logic signed [PW-1:0]     s2_q [LANES];
  logic signed [ACC_W-1:0]  sum_i, sum_q, s3_i, s3_q, acc_i, acc_q;

  always_comb begin
    logic signed [MW-1:0] m_ic, m_qs, m_qc, m_is;
    m_ic = '0; m_qs = '0; m_qc = '0; m_is = '0;
    for (int l = 0; l < LANES; l++) begin
      m_ic   = MW'(s1_i[l]) * MW'(cos_lut[s1_ph[l]]);
      m_qs   = MW'(s1_q[l]) * MW'(sin_lut[s1_ph[l]]);
      m_qc   = MW'(s1_q[l]) * MW'(cos_lut[s1_ph[l]]);
      m_is   = MW'(s1_i[l]) * MW'(sin_lut[s1_ph[l]]);
      p_i[l] = PW'(m_ic) + PW'(m_qs);
      p_q[l] = PW'(m_qc) - PW'(m_is);
    end
    sum_i = '0;
    sum_q = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_i = sum_i + ACC_W'(s2_i[l]);
      sum_q = sum_q + ACC_W'(s2_q[l]);
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      {v1, v2, v3} <= '0;
      s3_i <= '0; s3_q <= '0; acc_i <= '0; acc_q <= '0;
      for (int l = 0; l < LANES; l++) begin
        s1_i[l] <= '0; s1_q[l] <= '0; s1_ph[l] <= '0; s2_i[l] <= '0; s2_q[l] <= '0;
      end
    end else begin
      v1 <= (state == INTEGRATE);
      v2 <= v1;
      v3 <= v2;
      for (int l = 0; l < LANES; l++) begin
        s1_i[l]  <= data_i_in[l*DATA_W +: DATA_W];
        s1_q[l]  <= data_q_in[l*DATA_W +: DATA_W];
        s1_ph[l] <= add_mod(base, lane_off[l]);
        s2_i[l]  <= p_i[l];
        s2_q[l]  <= p_q[l];
      end
      s3_i <= sum_i;
      s3_q <= sum_q;
      if (state == IDLE && trigger) begin
        acc_i <= '0;
        acc_q <= '0;
      end else if (v3) begin
        acc_i <= acc_i + s3_i;
        acc_q <= acc_q + s3_q;
      end
    end
  end

  // Shift-register FIFO: entry 0 is the head and drives the outputs straight from flops.
  logic [FIFO_DEPTH-1:0] fifo_vld, fifo_vld_n;
  logic [ACC_W-1:0]      fifo_i [FIFO_DEPTH];
  logic [ACC_W-1:0]      fifo_q [FIFO_DEPTH];
  logic [ACC_W-1:0]      fifo_i_n [FIFO_DEPTH];
  logic [ACC_W-1:0]      fifo_q_n [FIFO_DEPTH];
  logic                  push, pop, push_ok;

  assign push = (state == PUSH);
  assign pop  = fifo_vld[0] && res_ready;

  always_comb begin
    fifo_vld_n = fifo_vld;
    fifo_i_n   = fifo_i;
    fifo_q_n   = fifo_q;
    push_ok    = 1'b0;
    if (pop) begin
      for (int j = 0; j < FIFO_DEPTH - 1; j++) begin
        fifo_vld_n[j] = fifo_vld[j+1];
        fifo_i_n[j]   = fifo_i[j+1];
        fifo_q_n[j]   = fifo_q[j+1];
      end
      fifo_vld_n[FIFO_DEPTH-1] = 1'b0;
    end
    if (push) begin
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        if (!push_ok && !fifo_vld_n[j]) begin
          fifo_vld_n[j] = 1'b1;
          fifo_i_n[j]   = acc_i;
          fifo_q_n[j]   = acc_q;
          push_ok       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      fifo_vld     <= '0;
      overflow_err <= 1'b0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_i[j] <= '0;
        fifo_q[j] <= '0;
      end
    end else begin
      fifo_vld <= fifo_vld_n;
      fifo_i   <= fifo_i_n;
      fifo_q   <= fifo_q_n;
      if (push && !push_ok) overflow_err <= 1'b1;
    end
  end

  assign res_valid = fifo_vld[0];
  assign res_i     = fifo_i[0];
  assign res_q     = fifo_q[0];

endmodule
